// File: rtl/rv32_pkg.sv
// Shared constants and types for the RV32I pipeline memory subsystem.
// Holds the arbiter state encoding used by mem_port_arbiter.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating up-counter with synchronous clear, used to track how many data
// grants in a row were issued while a fetch was waiting.
module arb_streak_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    // Clear has priority so a fetch grant always restarts the streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between IF-stage fetches and
// MEM-stage loads/stores, with a streak limit so fetches cannot starve.
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_valid,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,

    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int                STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_e          state;
    logic [STREAK_W-1:0] streak;
    logic                fq;
    logic                dq;
    logic                fetch_forced;
    logic                grant_data;
    logic                grant_fetch;
    logic                streak_inc;
    logic                streak_clr;

    // A requester is ignored in its own completion cycle, otherwise a request
    // still held high while valid pulses would be granted a second time.
    assign fq = if_req & ~if_valid;
    assign dq = dm_req & ~dm_valid;

    assign fetch_forced = fq & (streak == STREAK_MAX);
    assign grant_data   = (state == ARB_IDLE) & dq & ~fetch_forced;
    assign grant_fetch  = (state == ARB_IDLE) & fq & ~grant_data;

    assign streak_inc = grant_data & fq;
    assign streak_clr = (grant_data & ~fq) | grant_fetch;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

    arb_streak_counter #(
        .MAX_COUNT (MAX_DATA_STREAK),
        .CNT_W     (STREAK_W)
    ) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (streak_inc),
        .clr   (streak_clr),
        .count (streak)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_data) begin
                        state     <= ARB_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                    end else if (grant_fetch) begin
                        state     <= ARB_FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end
                end
                ARB_FETCH: begin
                    if (mem_ready) begin
                        state    <= ARB_IDLE;
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                ARB_DATA: begin
                    if (mem_ready) begin
                        state    <= ARB_IDLE;
                        mem_req  <= 1'b0;
                        dm_valid <= 1'b1;
                        // Stores return nothing useful; keep the last load value.
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand-written
// sequences for reset-mid-access and fetch starvation.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    typedef struct {
        logic [31:0] if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ready, mem_rdata;
        logic [31:0] e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_mem_be;
        logic [31:0] e_if_valid, e_if_rdata, e_dm_valid, e_dm_rdata, e_stall_if, e_stall_mem;
    } vec_t;

    int n_cmp  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(
        input logic [31:0] ir, ia, dr, dw, da, dd, db, rdy, rd,
        input logic [31:0] mr, mw, ma, md, mb, iv, ird, dv, drd, si, sm);
        vec_t t;
        t.if_req = ir;  t.if_addr = ia;  t.dm_req = dr;  t.dm_we = dw;  t.dm_addr = da;
        t.dm_wdata = dd; t.dm_be = db;  t.mem_ready = rdy; t.mem_rdata = rd;
        t.e_mem_req = mr; t.e_mem_we = mw; t.e_mem_addr = ma; t.e_mem_wdata = md; t.e_mem_be = mb;
        t.e_if_valid = iv; t.e_if_rdata = ird; t.e_dm_valid = dv; t.e_dm_rdata = drd;
        t.e_stall_if = si; t.e_stall_mem = sm;
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   32'(mem_req),   0);
        chk({tag, "_mem_we"},    32'(mem_we),    0);
        chk({tag, "_mem_addr"},  mem_addr,       0);
        chk({tag, "_mem_wdata"}, mem_wdata,      0);
        chk({tag, "_mem_be"},    32'(mem_be),    0);
        chk({tag, "_if_valid"},  32'(if_valid),  0);
        chk({tag, "_dm_valid"},  32'(dm_valid),  0);
        chk({tag, "_if_rdata"},  if_rdata,       0);
        chk({tag, "_dm_rdata"},  dm_rdata,       0);
    endtask

    initial begin
        vec_t       tbl[15];
        logic       prev_req;
        int         ng;
        logic [10:0] seen;

        // fetch 0x10; load 0x100 vs fetch 0x14; store with 3-cycle latency;
        // dm_req held through dm_valid; mem_ready while idle.
        tbl[0]  = v(1,'h10, 0,0,0,0,0,            0,0,          0,0,0,0,0,                     0,0,          0,0,          1,0);
        tbl[1]  = v(1,'h10, 0,0,0,0,0,            1,'h00500093, 1,0,'h10,0,'hF,                0,0,          0,0,          1,0);
        tbl[2]  = v(1,'h10, 0,0,0,0,0,            0,0,          0,0,0,0,0,                     1,'h00500093, 0,0,          0,0);
        tbl[3]  = v(1,'h14, 1,0,'h100,0,'hF,      0,0,          0,0,0,0,0,                     0,'h00500093, 0,0,          1,1);
        tbl[4]  = v(1,'h14, 1,0,'h100,0,'hF,      1,'h11112222, 1,0,'h100,0,'hF,               0,'h00500093, 0,0,          1,1);
        tbl[5]  = v(1,'h14, 1,0,'h100,0,'hF,      0,0,          0,0,0,0,0,                     0,'h00500093, 1,'h11112222, 1,0);
        tbl[6]  = v(1,'h14, 0,0,0,0,0,            1,'h00A00113, 1,0,'h14,0,'hF,                0,'h00500093, 0,'h11112222, 1,0);
        tbl[7]  = v(1,'h14, 0,0,0,0,0,            0,0,          0,0,0,0,0,                     1,'h00A00113, 0,'h11112222, 0,0);
        tbl[8]  = v(0,0,    1,1,'h200,'hDEADBEEF,3, 0,0,        0,0,0,0,0,                     0,'h00A00113, 0,'h11112222, 0,1);
        tbl[9]  = v(0,0,    1,1,'h200,'hDEADBEEF,3, 0,0,        1,1,'h200,'hDEADBEEF,3,        0,'h00A00113, 0,'h11112222, 0,1);
        tbl[10] = v(0,0,    1,1,'h200,'hDEADBEEF,3, 0,0,        1,1,'h200,'hDEADBEEF,3,        0,'h00A00113, 0,'h11112222, 0,1);
        tbl[11] = v(0,0,    1,1,'h200,'hDEADBEEF,3, 1,'h55555555, 1,1,'h200,'hDEADBEEF,3,      0,'h00A00113, 0,'h11112222, 0,1);
        tbl[12] = v(0,0,    1,1,'h200,'hDEADBEEF,3, 0,0,        0,0,0,0,0,                     0,'h00A00113, 1,'h11112222, 0,0);
        tbl[13] = v(0,0,    0,0,0,0,0,            1,'h99999999, 0,0,0,0,0,                     0,'h00A00113, 0,'h11112222, 0,0);
        tbl[14] = v(0,0,    0,0,0,0,0,            0,0,          0,0,0,0,0,                     0,'h00A00113, 0,'h11112222, 0,0);

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_rel");
        chk("rst_rel_stall_if",  32'(stall_if),  0);
        chk("rst_rel_stall_mem", 32'(stall_mem), 0);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if_req    = tbl[i].if_req[0];
            if_addr   = tbl[i].if_addr;
            dm_req    = tbl[i].dm_req[0];
            dm_we     = tbl[i].dm_we[0];
            dm_addr   = tbl[i].dm_addr;
            dm_wdata  = tbl[i].dm_wdata;
            dm_be     = tbl[i].dm_be[3:0];
            mem_ready = tbl[i].mem_ready[0];
            mem_rdata = tbl[i].mem_rdata;
            #1;
            chk($sformatf("v%0d_mem_req", i),   32'(mem_req),   tbl[i].e_mem_req);
            chk($sformatf("v%0d_if_valid", i),  32'(if_valid),  tbl[i].e_if_valid);
            chk($sformatf("v%0d_if_rdata", i),  if_rdata,       tbl[i].e_if_rdata);
            chk($sformatf("v%0d_dm_valid", i),  32'(dm_valid),  tbl[i].e_dm_valid);
            chk($sformatf("v%0d_dm_rdata", i),  dm_rdata,       tbl[i].e_dm_rdata);
            chk($sformatf("v%0d_stall_if", i),  32'(stall_if),  tbl[i].e_stall_if);
            chk($sformatf("v%0d_stall_mem", i), 32'(stall_mem), tbl[i].e_stall_mem);
            if (tbl[i].e_mem_req[0]) begin
                chk($sformatf("v%0d_mem_we", i),    32'(mem_we),    tbl[i].e_mem_we);
                chk($sformatf("v%0d_mem_addr", i),  mem_addr,       tbl[i].e_mem_addr);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata,      tbl[i].e_mem_wdata);
                chk($sformatf("v%0d_mem_be", i),    32'(mem_be),    tbl[i].e_mem_be);
            end
        end

        // Reset asserted while a load is waiting on memory.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_be = 4'hF;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rmid_granted", 32'(mem_req), 1);
        @(posedge clk);
        #1;
        chk("rmid_waiting", 32'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_req_drop", 32'(mem_req), 0);
        chk("rmid_addr_clr", mem_addr,     0);
        dm_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rmid_no_valid%0d", c), 32'(dm_valid), 0);
            chk($sformatf("rmid_no_req%0d", c),   32'(mem_req),  0);
        end

        // Starvation: data keeps coming back; fetch dropped only in dm_valid
        // cycles so each data grant sees a waiting fetch. Bit set = fetch grant.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h40;
        mem_ready = 1'b1; mem_rdata = 32'h0000_1234;
        prev_req = 1'b0;
        ng = 0;
        seen = '0;
        for (int c = 0; c < 200 && ng < 11; c++) begin
            @(posedge clk);
            #1;
            if_req = ~dm_valid;
            if (mem_req && !prev_req) begin
                seen[ng] = (mem_addr == 32'h40);
                ng++;
            end
            prev_req = mem_req;
        end
        chk("streak_grant_count", ng,           11);
        chk("streak_grant_order", 32'(seen),    32'b100_0001_0000);

        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the RV32I 5-stage pipeline.
- Serialises accesses with a 3-state FSM and tolerates variable memory latency (mem_ready).
- Drives the stall_if / stall_mem signals consumed by the pipeline control logic, alongside the load-use hazard logic.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch waits before fetch is forced through once

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held high until if_valid
if_addr  input  ADDR_W  fetch address; stable while if_req
if_rdata  output  DATA_W  fetched instruction, valid when if_valid
if_valid  output  1  one-cycle completion pulse for fetch
dm_req  input  1  data request; held high until dm_valid
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_be  input  DATA_W/8  store byte enables
dm_rdata  output  DATA_W  load data, valid when dm_valid after a load
dm_valid  output  1  one-cycle completion pulse for load or store
mem_req  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_rdata  input  DATA_W  memory read data, sampled when mem_ready
mem_ready  input  1  access complete this cycle
stall_if  output  1  hold IF stage
stall_mem  output  1  hold MEM stage and everything upstream

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, streak=0.
  - All registered outputs 0: mem_*, if_valid, dm_valid, if_rdata, dm_rdata.
  - Reset mid-access aborts it: mem_req drops immediately, no valid pulse follows.
- Qualified requests:
  - fq = if_req & !if_valid
  - dq = dm_req & !dm_valid
  - This prevents re-granting a request in its own completion cycle.
- States:
  - IDLE: mem_req=0.
    - dq & !(fq & streak==MAX_DATA_STREAK) -> DATA; capture dm_we/addr/wdata/be.
    - Else fq -> FETCH; capture if_addr, mem_we=0, mem_be=all ones, mem_wdata=0.
    - Else stay in IDLE.
  - FETCH / DATA:
    - mem_req=1; mem_* come from capture registers and are stable for the whole access.
    - On mem_ready=1: next cycle state=IDLE and the matching valid pulses for exactly one cycle.
    - FETCH completion: if_rdata <= mem_rdata.
    - DATA completion: dm_rdata <= mem_rdata on loads only; stores leave dm_rdata unchanged.
- Latency: request seen in IDLE at cycle 0; mem_req high at cycle 1; valid at cycle N+1, where N is the first mem_ready cycle. Minimum 2 cycles req->valid. One idle cycle between back-to-back accesses.
- Streak counter (width $clog2(MAX_DATA_STREAK+1)), updated on each grant:
  - Data grant with fq=1: streak+1, saturating.
  - Data grant with fq=0: streak=0.
  - Fetch grant: streak=0.
- Stall outputs (combinational): stall_if = if_req & !if_valid; stall_mem = dm_req & !dm_valid.
- Boundary behaviour:
  - mem_ready while mem_req=0: ignored.
  - Request dropped mid-access (protocol violation): access still completes and valid pulses.
  - Both requests arriving in the same cycle: data wins unless the streak limit forces fetch.

Decomposition:
- Shared package rv32_pkg: FSM state encoding (ARB_IDLE, ARB_FETCH, ARB_DATA), XLEN=32, byte-enable width constant.
- Sub-module arb_streak_counter (saturating counter with clear) is natural. The FSM and capture registers stay in the top.

Test Plan:
- Reset with rst_n=0, then release -> all outputs 0, state IDLE. Assert rst_n=0 during a DATA access with mem_ready held 0 -> mem_req drops the same cycle, no dm_valid pulse.
- Single fetch: if_addr=0x0000_0010, memory returns 0x0050_0093 with mem_ready in the first mem_req cycle -> if_valid pulses 2 cycles after if_req with if_rdata=0x0050_0093; stall_if high until then.
- Load vs fetch in the same cycle: dm_addr=0x100, if_addr=0x14 -> data granted first (mem_addr=0x100, mem_we=0), then fetch (mem_addr=0x14). dm_valid precedes if_valid.
- Store with dm_be=4'b0011, dm_wdata=0xDEAD_BEEF, 3-cycle mem_ready delay -> mem_be=0011 and mem_wdata held stable for 3 cycles. dm_valid pulses once; dm_rdata unchanged.
- Starvation: dm_req re-issued continuously with if_req held high, MAX_DATA_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then the streak restarts from 0.
- Completion-cycle qualification: dm_req held one cycle past dm_valid -> no second grant for that request.
